mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Parametrised N-port arbiter in front of a single-port block RAM. It replaces the fixed two-way select mux between the frame-buffer writers and readers. Each client port requests memory access with a req/gnt handshake, and the arbiter chooses among them by round-robin or fixed priority, with optional burst lock. Read data is returned to the issuing port through a tagged latency pipeline matched to the RAM read latency.

## Interface
- N_PORTS, 4: number of client ports, 2..8.
- ADDR_W, 15: address width.
- DATA_W, 16: data width.
- RD_LAT, 1: RAM read latency in cycles, measured from mem_en to valid mem_dout; 1..4.
- MAX_BURST, 16: maximum consecutive grants to one locked port, 1..256.
- ROUND_ROBIN, 1: 1 selects rotating priority; 0 selects fixed priority, where the lowest index wins.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_PORTS  per-port access request.
- we  in  N_PORTS  per-port write flag; 0 means read.
- lock  in  N_PORTS  per-port burst hold request.
- addr  in  N_PORTS*ADDR_W  flattened; port p occupies [p*ADDR_W +: ADDR_W].
- din  in  N_PORTS*DATA_W  flattened write data, same packing.
- gnt  out  N_PORTS  one-hot or zero; access accepted at this edge.
- rvalid  out  N_PORTS  one-hot or zero; rdata belongs to this port.
- rdata  out  DATA_W  shared read-return data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data.

## Operation
- **Handshake**
  - Port raises req with we, addr and din valid, and holds them stable until it sees gnt.
  - gnt[p] is combinational from req and arbiter state in the same cycle; the transfer completes at that edge.
  - The port may drop req or present a new request in the cycle after gnt.
- **Arbitration**
  - At most one grant per cycle.
  - Round-robin mode: search starts at pointer ptr, wrapping modulo N_PORTS. After a grant to port p, ptr becomes (p+1) mod N_PORTS.
  - Fixed mode: ptr is ignored, and the lowest requesting index wins.
- **Burst lock**
  - If the port granted in the previous cycle still has req and lock high, it wins again, overriding the priority search. This holds while burst count bcnt < MAX_BURST.
  - bcnt resets to 1 on a grant to a different port, or on any non-lock grant.
  - When bcnt reaches MAX_BURST, that port is excluded for exactly one arbitration cycle if any other port is requesting; otherwise it is granted again and bcnt restarts at 1.
  - A locked burst ends as soon as lock or req drops.
- **Memory issue**
  - On a grant, mem_en, mem_we, mem_addr and mem_din are registered from the winner's inputs. They are valid in the cycle after gnt.
  - With no grant, mem_en = 0 and mem_we = 0; mem_addr and mem_din hold their last values.
- **Read return**
  - Each read grant pushes a valid bit and a port tag into an RD_LAT-deep shift register, aligned with mem_en.
  - When a tag exits the shift register, rvalid[tag] is asserted for one cycle and rdata = mem_dout. rdata is not registered: it is combinational passthrough of mem_dout.
  - Write grants push an invalid entry, so no rvalid results.
  - Returns occur in issue order; back-to-back reads give back-to-back rvalid.

## Timing
- **Reset values**:
  - Outputs: gnt = 0, rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_din = 0. rdata is passthrough and is unaffected.
  - Internal state: ptr = 0, bcnt = 0, shift register cleared.
- **Reset during operation**: in-flight reads are dropped and never produce rvalid. While rst is high, gnt stays 0.
- **Latency**:
  - gnt is in cycle t.
  - The memory access is issued in cycle t+1.
  - For a read, rvalid is in cycle t+1+RD_LAT.
- **Throughput**: one access per cycle, with any read/write mix.
- **Simultaneous events**:
  - A port can receive rvalid and gnt in the same cycle.
  - Lock and a round-robin turn in the same cycle: lock wins, subject to MAX_BURST.
- **Pointer wrap**: a grant to port N_PORTS-1 sets ptr = 0.

## Test plan
- **Reset**: assert rst with all req high. Required: gnt = 0 and mem_en = 0. The first cycle after release grants port 0, and mem_en = 1 in the next cycle.
- **Round-robin fairness**: N_PORTS = 4, all req held high, no lock. Required: grants go 0,1,2,3,0,1, one per cycle. mem_addr follows the granted port's addr, one cycle delayed.
- **Read return routing**: RD_LAT = 2.
  - Stimulus: port 2 reads addr 0x0010, then port 1 reads addr 0x0020. The RAM model holds 0xAAAA and 0x5555 at those addresses.
  - Required: rvalid[2] with rdata = 0xAAAA in cycle t+3, then rvalid[1] with rdata = 0x5555 in cycle t+4.
- **Burst lock limit**: MAX_BURST = 4. Port 0 has req and lock held; port 3 requests.
  - Required: port 0 is granted 4 consecutive cycles, then port 3 once, then port 0 resumes.
  - Variant: port 0 drops lock. Required: port 3 is granted on the next cycle.
- **Write/no-return and fixed mode**:
  - ROUND_ROBIN = 0, ports 1 and 3 request writes. Required: port 1 is granted first, and no rvalid appears.
  - Data check: port 1 writes 0x1234 to addr 0x7FFF. Required: mem_we = 1, mem_addr = 0x7FFF, mem_din = 0x1234.
- **Reset mid-read**: issue a read, then assert rst one cycle later. Required: no rvalid occurs for that read, and the shift register comes out of reset empty.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : N-port round-robin / fixed-priority arbiter with burst lock in
//            front of a single-port RAM; tagged read-return pipeline.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int N_PORTS     = 4,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16,
    parameter int RD_LAT      = 1,
    parameter int MAX_BURST   = 16,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS-1:0]          lock,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   din,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    input  logic [DATA_W-1:0]           mem_dout
);

    localparam int                  c_PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int                  c_BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_BCNT_W-1:0] c_MAX    = c_BCNT_W'(MAX_BURST);
    localparam logic [c_BCNT_W-1:0] c_ONE    = c_BCNT_W'(1);

    function automatic logic [c_PTR_W-1:0] f_wrap(input int v);
        return c_PTR_W'(v % N_PORTS);
    endfunction

    function automatic logic [N_PORTS-1:0] f_onehot(input logic [c_PTR_W-1:0] i);
        logic [N_PORTS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // k-th candidate in search order: rotated from the pointer, or plain index
    function automatic logic [c_PTR_W-1:0] f_cand(input logic [c_PTR_W-1:0] ptr, input int k);
        return (ROUND_ROBIN != 0) ? f_wrap(int'(ptr) + k) : f_wrap(k);
    endfunction

    logic [c_PTR_W-1:0]             r_ptr;
    logic [c_BCNT_W-1:0]            r_bcnt;
    logic [c_PTR_W-1:0]             r_last;
    logic                           r_last_vld;
    logic                           r_mem_en;
    logic                           r_mem_we;
    logic [ADDR_W-1:0]              r_mem_addr;
    logic [DATA_W-1:0]              r_mem_din;
    logic [RD_LAT:0]                r_pipe_vld;
    logic [RD_LAT:0][c_PTR_W-1:0]   r_pipe_tag;

    logic [N_PORTS-1:0]             w_last_oh;
    logic [N_PORTS-1:0]             w_elig;
    logic                           w_hold_req;
    logic                           w_hold;
    logic                           w_others;
    logic                           w_excl;
    logic [c_PTR_W-1:0]             w_win;
    logic                           w_win_vld;
    logic [c_PTR_W-1:0]             w_sel;
    logic                           w_sel_vld;
    logic                           w_issue_rd;

    // Lock continuation: previous winner still asking with lock and under the
    // burst limit. At the limit it sits out one cycle only if someone else waits.
    assign w_last_oh  = f_onehot(r_last);
    assign w_hold_req = r_last_vld & (|(req & lock & w_last_oh));
    assign w_hold     = w_hold_req & (r_bcnt < c_MAX);
    assign w_others   = |(req & ~w_last_oh);
    assign w_excl     = w_hold_req & ~w_hold & w_others;
    assign w_elig     = req & ~({N_PORTS{w_excl}} & w_last_oh);

    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (!w_win_vld && w_elig[f_cand(r_ptr, k)]) begin
                w_win_vld = 1'b1;
                w_win     = f_cand(r_ptr, k);
            end
        end
    end

    assign w_sel      = w_hold ? r_last : w_win;
    assign w_sel_vld  = ~rst & (w_hold | w_win_vld);
    assign w_issue_rd = w_sel_vld & ~we[w_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_bcnt     <= '0;
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else begin
            r_last_vld <= w_sel_vld;
            if (w_sel_vld) begin
                r_last <= w_sel;
                r_ptr  <= f_wrap(int'(w_sel) + 1);
                r_bcnt <= w_hold ? (r_bcnt + c_ONE) : c_ONE;
            end
        end
    end

    // Address and write data hold their last values between grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            r_mem_en <= w_sel_vld;
            r_mem_we <= w_sel_vld & we[w_sel];
            if (w_sel_vld) begin
                r_mem_addr <= addr[int'(w_sel)*ADDR_W +: ADDR_W];
                r_mem_din  <= din[int'(w_sel)*DATA_W +: DATA_W];
            end
        end
    end

    // Stage 0 lines up with mem_en; the last stage lines up with mem_dout
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
        end else begin
            r_pipe_vld <= {r_pipe_vld[RD_LAT-1:0], w_issue_rd};
            r_pipe_tag <= {r_pipe_tag[RD_LAT-1:0], w_sel};
        end
    end

    assign gnt      = w_sel_vld ? f_onehot(w_sel) : '0;
    assign rvalid   = r_pipe_vld[RD_LAT] ? f_onehot(r_pipe_tag[RD_LAT]) : '0;
    assign rdata    = mem_dout;
    assign mem_en   = r_mem_en;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule
`default_nettype wire
